// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: keeps a display prefetch FIFO ahead of the raster
// and gives every spare RAM cycle to a valid/ready pixel writer.
module vga_fb_arbiter #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              display_on,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [5:0]        wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [5:0]        mem_wdata,
  input  logic [5:0]        mem_rdata,
  output logic [5:0]        pix_out,
  output logic              underrun
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LVL_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] NPIX      = ADDR_W'(H_VISIBLE * V_VISIBLE);
  localparam logic [LVL_W-1:0]  LVL_LOW   = LVL_W'(LOW_WATER);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [9:0]        V_RESTART = 10'(V_VISIBLE);

  logic [5:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [1:0]        rd_pend_q, rd_pend_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [5:0]        mem_wdata_q, mem_wdata_d;
  logic [5:0]        pix_q, pix_d;
  logic              underrun_q, underrun_d;

  logic              restart, fetch_ok, below_low, grant_fetch, grant_wr, wr_in_range;
  logic              push, pop;
  logic [LVL_W-1:0]  level;

  // level counts FIFO entries plus reads on the RAM bus (rd_pend_q[0]) and returning (rd_pend_q[1])
  always_comb begin
    restart     = (hcount == 11'd0) && (vcount == V_RESTART);
    level       = LVL_W'(cnt_q) + LVL_W'(rd_pend_q[0]) + LVL_W'(rd_pend_q[1]);
    fetch_ok    = (fetch_addr_q < NPIX) && !restart;
    below_low   = (level + LVL_W'(1)) <= LVL_LOW;
    wr_in_range = wr_addr < NPIX;
    grant_fetch = 1'b0;
    grant_wr    = 1'b0;
    if (fetch_ok && below_low) begin
      grant_fetch = 1'b1;
    end else if (wr_valid) begin
      grant_wr = 1'b1;
    end else if (fetch_ok && (level < LVL_FULL)) begin
      grant_fetch = 1'b1;
    end
    wr_ready = grant_wr && !reset;
  end

  always_comb begin
    push       = rd_pend_q[1] && !restart;
    pop        = display_on && (cnt_q != '0);
    pix_d      = 6'd0;
    underrun_d = underrun_q;
    if (display_on) begin
      if (cnt_q != '0) begin
        pix_d = fifo_mem_q[rd_ptr_q];
      end else begin
        underrun_d = 1'b1;
      end
    end

    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rd_pend_d    = {rd_pend_q[0], grant_fetch};
    fetch_addr_d = grant_fetch ? fetch_addr_q + ADDR_W'(1) : fetch_addr_q;
    // Frame restart drops queued and returning pixels; a write granted now still goes out.
    if (restart) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      rd_pend_d    = 2'b00;
      fetch_addr_d = '0;
    end

    mem_we_d    = grant_wr && wr_in_range;
    mem_en_d    = grant_fetch || mem_we_d;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant_fetch) begin
      mem_addr_d = fetch_addr_q;
    end else if (mem_we_d) begin
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      rd_pend_q    <= 2'b00;
      fetch_addr_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 6'd0;
      pix_q        <= 6'd0;
      underrun_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      rd_pend_q    <= rd_pend_d;
      fetch_addr_q <= fetch_addr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pix_q        <= pix_d;
      underrun_q   <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pix_out   = pix_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a shrunk 16x6 raster (24x8 total), plus a
// LOW_WATER=0 instance used to starve the FIFO and provoke underrun.
module tb_vga_fb_arbiter;
  localparam int HV = 16;
  localparam int VV = 6;
  localparam int HT = 24;
  localparam int VT = 8;
  localparam int NP = HV * VV;

  logic        clk = 1'b0;
  logic        reset, display_on, wr_valid, ram_load;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [18:0] wr_addr;
  logic [5:0]  wr_data;
  logic        wr_ready, mem_en, mem_we, underrun;
  logic [18:0] mem_addr;
  logic [5:0]  mem_wdata, mem_rdata, pix_out;

  logic        b_reset, b_display_on, b_wr_valid;
  logic        b_wr_ready, b_mem_en, b_mem_we, b_underrun;
  logic [18:0] b_mem_addr;
  logic [5:0]  b_mem_wdata, b_rdata, b_pix_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] ram [NP];

  assign b_rdata = 6'h15;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.H_VISIBLE(HV), .V_VISIBLE(VV), .ADDR_W(19), .FIFO_DEPTH(8), .LOW_WATER(4)) u_dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .display_on(display_on),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_out(pix_out), .underrun(underrun)
  );

  vga_fb_arbiter #(.H_VISIBLE(HV), .V_VISIBLE(VV), .ADDR_W(19), .FIFO_DEPTH(8), .LOW_WATER(0)) u_dut_lw0 (
    .clk(clk), .reset(b_reset), .hcount(hcount), .vcount(vcount), .display_on(b_display_on),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_rdata), .pix_out(b_pix_out), .underrun(b_underrun)
  );

  // Framebuffer RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < NP; i++) ram[i] <= 6'(i);
    end else if (mem_en && (mem_addr < 19'(NP))) begin
      if (mem_we) ram[mem_addr[6:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[6:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic de, input logic wv, input int wa, input int wd);
    hcount     = 11'(h);
    vcount     = 10'(v);
    display_on = de;
    wr_valid   = wv;
    wr_addr    = 19'(wa);
    wr_data    = 6'(wd);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [5:0] exp_pix(input int h, input int v);
    int idx;
    idx = v * HV + h;
    if (v >= VV || h >= HV) return 6'd0;
    if (idx == 10) return 6'h2A;
    return 6'(idx % 64);
  endfunction

  initial begin
    logic [5:0] prev_exp;
    logic       de, wv;
    int         v;
    ram_load = 1'b1; reset = 1'b1;
    b_reset = 1'b1; b_display_on = 1'b0; b_wr_valid = 1'b0;
    drive(1, VV, 0, 1, 0, 0);
    repeat (2) next_cycle();
    drive(1, VV, 0, 1, 0, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_wr_ready", wr_ready, 0);

    // Initial prefill: eight reads of addresses 0..7, then idle.
    next_cycle();
    reset = 1'b0; ram_load = 1'b0;
    drive(1, VV, 0, 0, 0, 0);
    chk("fill_c0_en", mem_en, 0);
    for (int k = 1; k <= 11; k++) begin
      next_cycle();
      drive(1, VV, 0, 0, 0, 0);
      if (k <= 8) begin
        chk("fill_en", mem_en, 1);
        chk("fill_we", mem_we, 0);
        chk("fill_addr", mem_addr, k - 1);
      end else begin
        chk("fill_idle_en", mem_en, 0);
      end
    end

    // Drain below LOW_WATER with a writer pending: fetch takes over at level 3.
    for (int k = 0; k <= 13; k++) begin
      next_cycle();
      drive(k, 0, k <= 10, k <= 12, 90, 26);
      if (k <= 12) chk("lw_wr_ready", wr_ready, (k <= 4 || k == 12) ? 1 : 0);
      if (k <= 11) chk("lw_pix", pix_out, (k == 0) ? 0 : k - 1);
      if (k == 12) chk("lw_pix_off", pix_out, 0);
      if (k == 1) begin
        chk("lw_wr_we", mem_we, 1);
        chk("lw_wr_addr", mem_addr, 90);
        chk("lw_wr_data", mem_wdata, 26);
      end
      if (k == 6) begin
        chk("lw_fetch_en", mem_en, 1);
        chk("lw_fetch_we", mem_we, 0);
        chk("lw_fetch_addr", mem_addr, 8);
      end
      if (k == 13) chk("lw_late_we", mem_we, 1);
    end
    chk("lw_underrun", underrun, 0);

    // Out-of-range write: handshake completes, RAM untouched.
    repeat (12) begin
      next_cycle();
      drive(1, VV, 0, 0, 0, 0);
    end
    next_cycle();
    drive(1, VV, 0, 1, NP, 63);
    chk("oor_ready", wr_ready, 1);
    next_cycle();
    drive(1, VV, 0, 0, 0, 0);
    chk("oor_en", mem_en, 0);
    chk("oor_we", mem_we, 0);

    // Two frames from the restart point; the vblank write shows at pixel 10.
    prev_exp = 6'd0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < VT; j++) begin
        v = (j + VV) % VT;
        for (int h = 0; h < HT; h++) begin
          de = (v < VV) && (h < HV);
          wv = (p == 0) && (v == VT - 1) && (h < 4);
          next_cycle();
          drive(h, v, de, wv, 10, 'h2A);
          chk("frame_pix", pix_out, prev_exp);
          if (wv) chk("vb_wr_ready", wr_ready, 1);
          if (p == 0 && v == VT - 1 && h >= 1 && h <= 4) begin
            chk("vb_we", mem_we, 1);
            chk("vb_addr", mem_addr, 10);
            chk("vb_data", mem_wdata, 'h2A);
          end
          prev_exp = de ? exp_pix(h, v) : 6'd0;
        end
      end
    end
    chk("frame_underrun", underrun, 0);

    // LOW_WATER=0 instance: writes starve the FIFO, then a pop underruns.
    for (int f = 0; f <= 16; f++) begin
      next_cycle();
      b_reset      = (f >= 15);
      b_display_on = (f == 2) || (f >= 14);
      b_wr_valid   = (f <= 2) || (f >= 14);
      drive(1, VV, 0, 0, 20, 'h0F);
      if (f == 0 || f == 2) chk("b_wr_ready", b_wr_ready, 1);
      if (f == 1) begin
        chk("b_wr_we", b_mem_we, 1);
        chk("b_wr_addr", b_mem_addr, 20);
      end
      if (f == 3) begin
        chk("b_empty_pix", b_pix_out, 0);
        chk("b_underrun_set", b_underrun, 1);
      end
      if (f == 13) chk("b_underrun_sticky", b_underrun, 1);
      if (f == 15) begin
        chk("b_rst_wr_ready", b_wr_ready, 0);
        chk("b_pre_wdata", b_mem_wdata, 'h0F);
        chk("b_pre_pix", b_pix_out, 'h15);
        chk("b_pre_underrun", b_underrun, 1);
      end
      if (f == 16) begin
        chk("b_rst_pix", b_pix_out, 0);
        chk("b_rst_underrun", b_underrun, 0);
        chk("b_rst_en", b_mem_en, 0);
        chk("b_rst_we", b_mem_we, 0);
        chk("b_rst_addr", b_mem_addr, 0);
        chk("b_rst_wdata", b_mem_wdata, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter between the VGA display path and a pixel-write requester. It keeps a small display prefetch FIFO filled from framebuffer RAM, ahead of the raster position produced by the VGA counter. It hands every spare RAM cycle to the writer through a valid/ready handshake. It sits between the counter's hcount/vcount/display_on outputs, the framebuffer RAM and the 2-bit-per-channel colour outputs.

## Interface
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- ADDR_W, 19, framebuffer address width; must hold H_VISIBLE*V_VISIBLE-1
- FIFO_DEPTH, 8, prefetch FIFO entries (power of two, ≥4)
- LOW_WATER, 4, fill level below which fetch outranks writes

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- hcount  in  11  current horizontal position
- vcount  in  10  current vertical position
- display_on  in  1  high in visible area
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle when wr_valid also high
- wr_addr  in  ADDR_W  linear pixel address (y*H_VISIBLE+x)
- wr_data  in  6  {r,g,b}, 2 bits each
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  6  RAM write data
- mem_rdata  in  6  read data, valid exactly 1 cycle after mem_en with mem_we=0
- pix_out  out  6  {r,g,b} to DAC pins
- underrun  out  1  sticky: display needed a pixel from an empty FIFO

## Operation
- Occupancy `level` = FIFO entries + reads in flight. A read reserves its slot when granted.
- Grant decision each cycle (cycle N), in priority order:
  - FETCH if level < LOW_WATER and fetch_addr < H_VISIBLE*V_VISIBLE.
  - WRITE if wr_valid.
  - FETCH if level < FIFO_DEPTH and fetch_addr not exhausted.
  - IDLE otherwise.
- wr_ready is high only in cycles where WRITE is granted. It is combinational from wr_valid and level, and forced 0 while reset is high.
- Granted operation is registered onto the mem_* outputs in cycle N+1.
  - FETCH: mem_en=1, mem_we=0, mem_addr=fetch_addr; fetch_addr increments in N.
  - WRITE: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - IDLE: mem_en=0, mem_we=0.
- Write with wr_addr ≥ H_VISIBLE*V_VISIBLE: handshake completes, but mem_en and mem_we stay 0 (write dropped).
- Read data is pushed into the FIFO in cycle N+2.
- Pop: each cycle display_on=1, one FIFO entry is popped and registered into pix_out. In the same cycle display_on=0, pix_out is set to 0.
- Empty pop: display_on=1 with FIFO empty gives pix_out=0 and sets underrun. underrun is cleared only by reset.
- Frame restart when hcount==0 and vcount==V_VISIBLE:
  - FIFO flushed and fetch_addr=0.
  - Reads still in flight are discarded on return and not pushed.
  - A write granted in that cycle still completes.
- Simultaneous push and pop: both take effect; level is unchanged.

## Timing
- Reset values: pix_out=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, underrun=0, wr_ready=0. FIFO empty, fetch_addr=0, nothing in flight.
- Pixel latency: pix_out for raster position (hcount,vcount) is valid 1 cycle after the cycle that position is presented.
- Grant to RAM strobe: 1 cycle. Fetch grant to FIFO push: 2 cycles.
- After frame restart, the FIFO refills to FIFO_DEPTH within FIFO_DEPTH+2 cycles if wr_valid=0. Vertical blanking always covers this refill.
- Steady state in the visible area: 1 pop per cycle forces continuous FETCH. The writer is served only during horizontal and vertical blanking, or when level ≥ LOW_WATER.
- Reset asserted mid-operation: the state returns to reset values on the next edge, and in-flight read data is ignored.

## Test plan
- Reset, then idle with display_on=0 → within 10 cycles, 8 reads at mem_addr 0..7, then mem_en=0 and level=8.
- Preload RAM[i]=i[5:0], drive the full 800x525 raster → pix_out equals the pixel index mod 64 at every visible position, 1 cycle late, and underrun stays 0.
- During vertical blank with the FIFO full, hold wr_valid=1 with addr=100, data=6'h2A → wr_ready=1 every cycle, mem_we=1 next cycle; the next frame shows 6'h2A at x=100,y=0.
- Level=3 (below LOW_WATER) and wr_valid=1 in the same cycle → FETCH granted, wr_ready=0, write served on a later cycle.
- wr_addr=307200 with wr_valid=1 → handshake completes, mem_we stays 0.
- Hold the FIFO empty by forcing writes to win (LOW_WATER=0 build), then assert display_on → pix_out=0 and underrun=1, remaining 1 until reset; reset mid-line → all outputs 0 on the next edge.
